// File: rtl/posit_rne_rounder.sv
// One-cycle round-to-nearest-even of an unpacked posit onto the WIDTH/ES grid.
// Define POSIT_RNE_PACKED_OUT_EN to add the encoded out_packed output.
module posit_rne_rounder #(
  parameter int WIDTH         = 8,
  parameter int ES            = 1,
  parameter int TRAILING_BITS = 2,
  localparam int FRAC_BITS    = WIDTH - 3 - ES,
  localparam int EXP_BITS     = $clog2(WIDTH - 1) + ES + 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_sign,
  input  logic                       in_is_inf,
  input  logic                       in_is_zero,
  input  logic signed [EXP_BITS-1:0] in_exponent,
  input  logic [FRAC_BITS-1:0]       in_fraction,
  input  logic [TRAILING_BITS-1:0]   trailing_bits,
  input  logic                       sticky_bit,
  output logic                       out_valid,
  output logic                       out_sign,
  output logic                       out_is_inf,
  output logic                       out_is_zero,
  output logic signed [EXP_BITS-1:0] out_exponent,
  output logic [FRAC_BITS-1:0]       out_fraction
`ifdef POSIT_RNE_PACKED_OUT_EN
  ,
  output logic [WIDTH-1:0]           out_packed
`endif
);

  localparam int N    = WIDTH - 1;
  localparam int BODY = ES + FRAC_BITS + TRAILING_BITS + 1;
  localparam int LV   = BODY + N + 2;
  localparam int RUNW = $clog2(N + 2);
  localparam logic signed [EXP_BITS-1:0] EMAX = EXP_BITS'((WIDTH - 2) << ES);
  localparam logic signed [EXP_BITS-1:0] EMIN = -EMAX;

  logic [BODY-1:0]            w_body;
  logic signed [EXP_BITS-1:0] w_k;
  logic [EXP_BITS-1:0]        w_sh_pos;
  logic [EXP_BITS-1:0]        w_sh_neg;
  logic signed [LV-1:0]       w_x;
  logic signed [LV-1:0]       w_str_pos;
  logic [LV-1:0]              w_y;
  logic [LV-1:0]              w_str;
  logic [N-1:0]               w_keep;
  logic                       w_guard;
  logic                       w_st;
  logic                       w_up;
  logic                       w_sat_hi;
  logic                       w_sat_lo;
  logic [N-1:0]               w_mag;
  logic [RUNW-1:0]            w_run;
  logic                       w_run_done;
  logic [N-1:0]               w_shift;
  logic [EXP_BITS-1:0]        w_es_d;
  logic signed [EXP_BITS-1:0] w_kd;
  logic signed [EXP_BITS-1:0] w_exp_d;
  logic [FRAC_BITS-1:0]       w_frac_d;

  logic                       r_valid;
  logic                       r_sign;
  logic                       r_is_inf;
  logic                       r_is_zero;
  logic signed [EXP_BITS-1:0] r_exponent;
  logic [FRAC_BITS-1:0]       r_fraction;

  // Low ES exponent bits, fraction, trailing and sticky form the bits after the regime.
  assign w_body   = BODY'({in_exponent, in_fraction, trailing_bits, sticky_bit});
  assign w_k      = in_exponent >>> ES;
  assign w_sh_pos = w_k;
  assign w_sh_neg = EXP_BITS'(-w_k);

  // Positive regimes: arithmetic shift replicates the leading one k extra times.
  assign w_x       = {2'b10, w_body, {N{1'b0}}};
  assign w_str_pos = w_x >>> w_sh_pos;
  assign w_y       = {1'b1, w_body, {(N + 1){1'b0}}};
  assign w_str     = w_k[EXP_BITS-1] ? (w_y >> w_sh_neg) : w_str_pos;

  assign w_keep   = w_str[LV-1 -: N];
  assign w_guard  = w_str[LV-1-N];
  assign w_st     = |w_str[LV-2-N:0];
  assign w_up     = w_guard & (w_st | w_keep[0]) & ~(&w_keep);
  assign w_sat_hi = in_exponent > EMAX;
  assign w_sat_lo = in_exponent < EMIN;

  // Rounded magnitude, clamped to [minpos, maxpos].
  always_comb begin
    if (w_sat_hi) begin
      w_mag = {N{1'b1}};
    end else if (w_sat_lo) begin
      w_mag = N'(1);
    end else begin
      w_mag = w_keep + N'(w_up);
    end
  end

  // Regime run length of the rounded magnitude.
  always_comb begin
    w_run      = RUNW'(0);
    w_run_done = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!w_run_done && (w_mag[i] == w_mag[N-1])) begin
        w_run = w_run + RUNW'(1);
      end else begin
        w_run_done = 1'b1;
      end
    end
  end

  // Bits past the regime terminator; missing low bits shift in as zeros.
  assign w_shift  = w_mag << (w_run + RUNW'(1));
  assign w_es_d   = EXP_BITS'(w_shift >> (N - ES));
  assign w_frac_d = FRAC_BITS'(w_shift >> (N - ES - FRAC_BITS));
  assign w_kd     = w_mag[N-1] ? (EXP_BITS'(w_run) - EXP_BITS'(1)) : -EXP_BITS'(w_run);
  assign w_exp_d  = (w_kd << ES) | w_es_d;

  // Output register; specials drop sign and ignore rounding inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_sign     <= 1'b0;
      r_is_inf   <= 1'b0;
      r_is_zero  <= 1'b0;
      r_exponent <= '0;
      r_fraction <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_is_inf) begin
        r_sign     <= 1'b0;
        r_is_inf   <= 1'b1;
        r_is_zero  <= 1'b0;
        r_exponent <= '0;
        r_fraction <= '0;
      end else if (in_is_zero) begin
        r_sign     <= 1'b0;
        r_is_inf   <= 1'b0;
        r_is_zero  <= 1'b1;
        r_exponent <= '0;
        r_fraction <= '0;
      end else begin
        r_sign     <= in_sign;
        r_is_inf   <= 1'b0;
        r_is_zero  <= 1'b0;
        r_exponent <= w_exp_d;
        r_fraction <= w_frac_d;
      end
    end
  end

  assign out_valid    = r_valid;
  assign out_sign     = r_sign;
  assign out_is_inf   = r_is_inf;
  assign out_is_zero  = r_is_zero;
  assign out_exponent = r_exponent;
  assign out_fraction = r_fraction;

`ifdef POSIT_RNE_PACKED_OUT_EN
  logic [WIDTH-1:0] w_pack_mag;
  logic [WIDTH-1:0] r_packed;

  assign w_pack_mag = {1'b0, w_mag};

  // Encoded posit register: negatives are the two's complement of the magnitude.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_packed <= '0;
    end else if (in_is_inf) begin
      r_packed <= {1'b1, {N{1'b0}}};
    end else if (in_is_zero) begin
      r_packed <= '0;
    end else if (in_sign) begin
      r_packed <= WIDTH'(0) - w_pack_mag;
    end else begin
      r_packed <= w_pack_mag;
    end
  end

  assign out_packed = r_packed;
`endif

endmodule

// File: tb/tb_posit_rne_rounder.sv
// Directed and exhaustive check of posit_rne_rounder at WIDTH=6, ES=0, TRAILING_BITS=2.
module tb_posit_rne_rounder;
  localparam int WIDTH = 6;
  localparam int ES    = 0;
  localparam int TB    = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid, in_sign, in_is_inf, in_is_zero, sticky_bit;
  logic [3:0] in_exponent;
  logic [2:0] in_fraction;
  logic [1:0] trailing_bits;
  logic       out_valid, out_sign, out_is_inf, out_is_zero;
  logic [3:0] out_exponent;
  logic [2:0] out_fraction;
`ifdef POSIT_RNE_PACKED_OUT_EN
  logic [5:0] out_packed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  posit_rne_rounder #(.WIDTH(WIDTH), .ES(ES), .TRAILING_BITS(TB)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_sign(in_sign),
    .in_is_inf(in_is_inf), .in_is_zero(in_is_zero), .in_exponent(in_exponent),
    .in_fraction(in_fraction), .trailing_bits(trailing_bits), .sticky_bit(sticky_bit),
    .out_valid(out_valid), .out_sign(out_sign), .out_is_inf(out_is_inf),
    .out_is_zero(out_is_zero), .out_exponent(out_exponent), .out_fraction(out_fraction)
`ifdef POSIT_RNE_PACKED_OUT_EN
    , .out_packed(out_packed)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic v, input logic s, input logic inf,
                                       input logic z, input logic [3:0] e, input logic [2:0] f);
    return {21'd0, v, s, inf, z, e, f};
  endfunction

  function automatic logic [31:0] obs();
    return {21'd0, out_valid, out_sign, out_is_inf, out_is_zero, out_exponent, out_fraction};
  endfunction

  task automatic apply(input logic v, input logic s, input logic inf, input logic z,
                       input logic [3:0] e, input logic [2:0] f, input logic [1:0] t,
                       input logic st);
    in_valid = v; in_sign = s; in_is_inf = inf; in_is_zero = z;
    in_exponent = e; in_fraction = f; trailing_bits = t; sticky_bit = st;
    @(posedge clock);
    #1;
  endtask

  task automatic vec(input string tag, input logic s, input logic [3:0] e, input logic [2:0] f,
                     input logic [1:0] t, input logic st, input logic es,
                     input logic [3:0] ee, input logic [2:0] ef);
    apply(1'b1, s, 1'b0, 1'b0, e, f, t, st);
    check_eq(tag, obs(), word(1'b1, es, 1'b0, 1'b0, ee, ef));
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) begin
      for (int i = 0; i < k; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -k; i++) r = r / 2.0;
    end
    return r;
  endfunction

  // Reference decode of a 5-bit positive posit magnitude into regime exponent and 3-bit fraction.
  function automatic void dec(input int mag, output int k, output int f3);
    int r0, run, i;
    r0 = (mag >> 4) & 1;
    run = 0;
    i = 4;
    while (i >= 0 && (((mag >> i) & 1) == r0)) begin
      run++;
      i--;
    end
    k = (r0 == 1) ? run - 1 : -run;
    i--;
    if (i >= 0) f3 = (mag & ((1 << (i + 1)) - 1)) << (3 - (i + 1));
    else f3 = 0;
  endfunction

  function automatic real val(input int mag);
    int k, f3;
    dec(mag, k, f3);
    return pow2(k) * (1.0 + f3 / 8.0);
  endfunction

  initial begin
    int k, f3, mag, best, ek, ef;
    logic s;
    real x, d, bd;

    reset = 1'b1;
    in_valid = 1'b0; in_sign = 1'b0; in_is_inf = 1'b0; in_is_zero = 1'b0;
    in_exponent = 4'd0; in_fraction = 3'd0; trailing_bits = 2'd0; sticky_bit = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_state", obs(), 32'd0);
    reset = 1'b0;

    vec("one_tie_even",    1'b0, 4'd0,  3'b000, 2'b10, 1'b0, 1'b0, 4'd0,  3'b000);
    vec("one_tie_sticky",  1'b0, 4'd0,  3'b000, 2'b10, 1'b1, 1'b0, 4'd0,  3'b001);
    vec("odd_tie_up",      1'b0, 4'd0,  3'b001, 2'b10, 1'b0, 1'b0, 4'd0,  3'b010);
    vec("below_half",      1'b0, 4'd0,  3'b001, 2'b01, 1'b1, 1'b0, 4'd0,  3'b001);
    vec("carry_to_regime", 1'b0, 4'd0,  3'b111, 2'b11, 1'b0, 1'b0, 4'd1,  3'b000);
    vec("regime_trunc",    1'b0, 4'd1,  3'b001, 2'b00, 1'b0, 1'b0, 4'd1,  3'b000);
    vec("regime_trunc_up", 1'b0, 4'd1,  3'b011, 2'b00, 1'b0, 1'b0, 4'd1,  3'b100);
    vec("no_frac_tie",     1'b0, 4'd3,  3'b100, 2'b00, 1'b0, 1'b0, 4'd3,  3'b000);
    vec("maxpos_sat",      1'b0, 4'd4,  3'b000, 2'b11, 1'b1, 1'b0, 4'd4,  3'b000);
    vec("minpos_floor",    1'b0, 4'hC,  3'b000, 2'b00, 1'b0, 1'b0, 4'hC,  3'b000);
    vec("neg_tie",         1'b1, 4'd0,  3'b001, 2'b10, 1'b0, 1'b1, 4'd0,  3'b010);
    vec("exp_over",        1'b0, 4'd5,  3'b010, 2'b01, 1'b0, 1'b0, 4'd4,  3'b000);
    vec("exp_under",       1'b1, 4'hB,  3'b111, 2'b11, 1'b1, 1'b1, 4'hC,  3'b000);

    for (int t = 0; t < 4; t++) begin
      for (int st = 0; st < 2; st++) begin
        apply(1'b1, 1'b1, 1'b1, st[0], 4'd3, 3'b101, t[1:0], st[0]);
        check_eq("inf_pass", obs(), word(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0));
        apply(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 3'b011, t[1:0], st[0]);
        check_eq("zero_pass", obs(), word(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0));
      end
    end

    apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 2'd0, 1'b0);
    check_eq("valid_low", {31'd0, out_valid}, 32'd0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 3'd0, 2'd0, 1'b0);
    check_eq("valid_high", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("async_reset", obs(), 32'd0);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int code = 0; code < 64; code++) begin
      for (int t = 0; t < 4; t++) begin
        for (int st = 0; st < 2; st++) begin
          if (code == 0) begin
            apply(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, t[1:0], st[0]);
            check_eq("sweep_zero", obs(), word(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0));
`ifdef POSIT_RNE_PACKED_OUT_EN
            check_eq("sweep_pk_zero", {26'd0, out_packed}, 32'd0);
`endif
          end else if (code == 32) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0, t[1:0], st[0]);
            check_eq("sweep_inf", obs(), word(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0));
`ifdef POSIT_RNE_PACKED_OUT_EN
            check_eq("sweep_pk_inf", {26'd0, out_packed}, 32'd32);
`endif
          end else begin
            s = (code >= 32);
            mag = s ? (64 - code) : code;
            dec(mag, k, f3);
            x = val(mag) + pow2(k) * (t / 32.0 + st / 256.0);
            best = 1;
            bd = (x > val(1)) ? x - val(1) : val(1) - x;
            for (int c = 2; c < 32; c++) begin
              d = (x > val(c)) ? x - val(c) : val(c) - x;
              if (d < bd || (d == bd && (c % 2 == 0))) begin
                best = c;
                bd = d;
              end
            end
            dec(best, ek, ef);
            apply(1'b1, s, 1'b0, 1'b0, k[3:0], f3[2:0], t[1:0], st[0]);
            check_eq($sformatf("sweep_c%0d_t%0d_s%0d", code, t, st), obs(),
                     word(1'b1, s, 1'b0, 1'b0, ek[3:0], ef[2:0]));
`ifdef POSIT_RNE_PACKED_OUT_EN
            check_eq("sweep_packed", {26'd0, out_packed},
                     32'(s ? ((64 - best) & 63) : best));
`endif
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
